// File: rtl/series_pkg.sv
// series_pkg
// Shared definitions for the series-evaluation datapath: default result width and
// buffer depth, the packed result record and the saturation constant.
package series_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_DEPTH  = 4;

   // One buffered result at the default width: {overflow, data}.
   typedef struct packed {
      logic                  overflow;
      logic [DEF_DATA_W-1:0] data;
   } result_t;

   // Largest positive two's-complement value at the default width.
   localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};

endpackage

// File: rtl/series_result_mem.sv
// series_result_mem
// DEPTH x WIDTH register array, cleared by reset, with one synchronous write port
// and one asynchronous (combinational) read port.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   we, waddr, wdata  - write enable, address, word
//   raddr, rdata      - read address, read word (same cycle)
module series_result_mem #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/series_result_buffer.sv
// series_result_buffer
// Output FIFO of the series-evaluation datapath. Never back-pressures the producer:
// a result arriving while full (and not being popped) is dropped and drop_err is set.
// First-word fall-through towards the consumer.
// Ports:
//   clk, rst                           - clock, asynchronous active-high reset
//   in_valid, in_data, in_overflow     - result strobe, word and overflow flag
//   out_valid, out_data, out_overflow  - head entry presented downstream
//   out_ready                          - consumer accepts head entry
//   count                              - occupancy 0..DEPTH
//   drop_err, err_clr                  - sticky drop flag and its synchronous clear
// Build option: SERIES_RESULT_SATURATE_EN replaces the word of an overflowed result
// with the maximum positive value before storing it.
module series_result_buffer
   import series_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_overflow,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_overflow,
   input  logic                    out_ready,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    drop_err,
   input  logic                    err_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
   localparam logic [DATA_W-1:0] SatWord = {1'b0, {(DATA_W-1){1'b1}}};

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          drop_err_q, drop_err_d;

   logic          full, push, pop, drop;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W:0]   rd_word;

   assign full = (count_q == FullCnt);
   assign pop  = out_valid & out_ready;
   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign push = in_valid & (~full | pop);
   assign drop = in_valid & full & ~pop;

`ifdef SERIES_RESULT_SATURATE_EN
   assign wr_data = in_overflow ? SatWord : in_data;
`else
   assign wr_data = in_data;
`endif

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Set wins over a simultaneous clear.
      drop_err_d = drop | (drop_err_q & ~err_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_err_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_err_q <= drop_err_d;
      end
   end

   series_result_mem #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata ({in_overflow, wr_data}),
      .raddr (rd_ptr_q),
      .rdata (rd_word)
   );

   assign out_valid    = (count_q != '0);
   assign out_data     = rd_word[DATA_W-1:0];
   assign out_overflow = rd_word[DATA_W];
   assign count        = count_q;
   assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_series_result_buffer.sv
module tb_series_result_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_overflow = 1'b0;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_overflow;
   logic        out_ready = 1'b0;
   logic [2:0]  count;
   logic        drop_err;
   logic        err_clr = 1'b0;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   series_result_buffer #(
      .DATA_W (16),
      .DEPTH  (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_overflow  (in_overflow),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_overflow (out_overflow),
      .out_ready    (out_ready),
      .count        (count),
      .drop_err     (drop_err),
      .err_clr      (err_clr)
   );

   // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
      else passed++;
      total++;
      if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count);
      else passed++;
      total++;
      if (drop_err !== 1'b0) $display("FAIL reset_drop_err: got %b want 0", drop_err);
      else passed++;
      total++;
      if ({out_overflow, out_data} !== 17'h0)
         $display("FAIL reset_head: got %h want 0", {out_overflow, out_data});
      else passed++;
   endtask

   task automatic test_basic();
      in_valid = 1'b1; in_data = 16'h0012; step();
      total++;
      if (out_valid !== 1'b1) $display("FAIL basic_latency: got %b want 1", out_valid);
      else passed++;
      in_data = 16'h0034; step();
      in_valid = 1'b0; in_data = 16'hDEAD;
      total++;
      if (count !== 3'd2) $display("FAIL basic_count2: got %0d want 2", count);
      else passed++;
      total++;
      if (out_data !== 16'h0012) $display("FAIL basic_head: got %h want 0012", out_data);
      else passed++;
      step();
      total++;
      if (out_data !== 16'h0012) $display("FAIL basic_stable: got %h want 0012", out_data);
      else passed++;
      out_ready = 1'b1; step();
      total++;
      if (out_data !== 16'h0034 || count !== 3'd1)
         $display("FAIL basic_pop1: got %h/%0d want 0034/1", out_data, count);
      else passed++;
      step();
      out_ready = 1'b0;
      total++;
      if (count !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL basic_empty: got %0d/%b want 0/0", count, out_valid);
      else passed++;
   endtask

   task automatic test_drop();
      in_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_data = 16'(i);
         step();
         if (i == 4) begin
            total++;
            if (count !== 3'd4 || drop_err !== 1'b0)
               $display("FAIL drop_full: got %0d/%b want 4/0", count, drop_err);
            else passed++;
         end
      end
      in_valid = 1'b0;
      total++;
      if (count !== 3'd4) $display("FAIL drop_count: got %0d want 4", count);
      else passed++;
      total++;
      if (drop_err !== 1'b1) $display("FAIL drop_flag: got %b want 1", drop_err);
      else passed++;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== 16'(i))
            $display("FAIL drop_drain%0d: got %b/%h want 1/%h", i, out_valid, out_data, 16'(i));
         else passed++;
         step();
      end
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || count !== 3'd0)
         $display("FAIL drop_after: got %b/%0d want 0/0", out_valid, count);
      else passed++;
      total++;
      if (drop_err !== 1'b1) $display("FAIL drop_sticky: got %b want 1", drop_err);
      else passed++;
   endtask

   task automatic test_err_clr();
      // Refill, then clear and drop in the same cycle: set wins.
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 16'h0100 + 16'(i); step();
      end
      err_clr = 1'b1; in_data = 16'h0BAD; step();
      in_valid = 1'b0;
      total++;
      if (drop_err !== 1'b1) $display("FAIL clr_set_wins: got %b want 1", drop_err);
      else passed++;
      step();
      err_clr = 1'b0;
      total++;
      if (drop_err !== 1'b0) $display("FAIL clr_clears: got %b want 0", drop_err);
      else passed++;
      out_ready = 1'b1;
      repeat (4) step();
      out_ready = 1'b0;
      total++;
      if (count !== 3'd0) $display("FAIL clr_drain: got %0d want 0", count);
      else passed++;
   endtask

   task automatic test_full_push_pop();
      logic [15:0] exp [4];
      exp[0] = 16'h00A2; exp[1] = 16'h00A3; exp[2] = 16'h00A4; exp[3] = 16'h00A5;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 16'h00A1 + 16'(i); step();
      end
      in_data = 16'h00A5; out_ready = 1'b1; step();
      in_valid = 1'b0;
      total++;
      if (count !== 3'd4 || drop_err !== 1'b0)
         $display("FAIL full_pp: got %0d/%b want 4/0", count, drop_err);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out_data !== exp[i])
            $display("FAIL full_drain%0d: got %h want %h", i, out_data, exp[i]);
         else passed++;
         step();
      end
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) $display("FAIL full_empty: got %b want 0", out_valid);
      else passed++;
   endtask

   task automatic test_overflow();
      logic [15:0] exp_sat;
`ifdef SERIES_RESULT_SATURATE_EN
      exp_sat = 16'h7FFF;
`else
      exp_sat = 16'h7000;
`endif
      in_valid = 1'b1; in_overflow = 1'b1; in_data = 16'h7000; step();
      in_overflow = 1'b0; in_data = 16'h1234; step();
      in_valid = 1'b0;
      total++;
      if (out_data !== exp_sat || out_overflow !== 1'b1)
         $display("FAIL ovf_head: got %h/%b want %h/1", out_data, out_overflow, exp_sat);
      else passed++;
      out_ready = 1'b1; step();
      total++;
      if (out_data !== 16'h1234 || out_overflow !== 1'b0)
         $display("FAIL ovf_next: got %h/%b want 1234/0", out_data, out_overflow);
      else passed++;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      // Streaming at occupancy 1: each cycle pushes one word and pops the previous.
      in_valid = 1'b1; out_ready = 1'b1;
      in_data = 16'h0200; step();
      for (int i = 1; i <= 5; i++) begin
         total++;
         if (count !== 3'd1 || out_data !== 16'h0200 + 16'(i - 1))
            $display("FAIL b2b_%0d: got %0d/%h want 1/%h", i, count, out_data,
                     16'h0200 + 16'(i - 1));
         else passed++;
         in_data = 16'h0200 + 16'(i); step();
      end
      in_valid = 1'b0; step();
      out_ready = 1'b0;
      total++;
      if (count !== 3'd0) $display("FAIL b2b_empty: got %0d want 0", count);
      else passed++;
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 16'h0300 + 16'(i); step();
      end
      in_valid = 1'b0;
      total++;
      if (count !== 3'd3) $display("FAIL arst_pre: got %0d want 3", count);
      else passed++;
      #2 rst = 1'b1;
      #1;
      total++;
      if (count !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL arst_now: got %0d/%b want 0/0", count, out_valid);
      else passed++;
      step();
      rst = 1'b0;
      step();
      total++;
      if (drop_err !== 1'b0 || count !== 3'd0)
         $display("FAIL arst_after: got %b/%0d want 0/0", drop_err, count);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_drop();
      test_err_clr();
      test_full_push_pop();
      test_overflow();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
